mmcm_drp_ctrl: RTL and testbench

//  Sequences run-time reconfiguration of the MMCM through its DRP port.

---
 rtl/mmcm_drp_ctrl_if.sv | 31 +++
 rtl/mmcm_drp_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_mmcm_drp_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmcm_drp_ctrl_if.sv
// Configuration-beat and DRP bus bundle for the MMCM reconfiguration controller.
// master: beat producer / DRP endpoint side. slave: the controller.
interface mmcm_drp_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [15:0] cfg_mask;
  logic        cfg_last;

  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_do;
  logic        drp_drdy;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_mask, cfg_last,
    input  cfg_ready,
    input  drp_daddr, drp_di, drp_den, drp_dwe,
    output drp_do, drp_drdy
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_mask, cfg_last,
    output cfg_ready,
    output drp_daddr, drp_di, drp_den, drp_dwe,
    input  drp_do, drp_drdy
  );
endinterface

// File: rtl/mmcm_drp_ctrl.sv
// MMCM run-time reconfiguration sequencer: masked read-modify-write of DRP
// registers while the MMCM is held in reset, then lock supervision and
// release of the downstream core reset.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a first beat; supervises lock while mmcm_rst is low
// HOLD    | mmcm_rst asserted, counting RST_HOLD cycles before first read
// RD      | one-cycle DRP read strobe
// WAIT_RD | waiting for read data; builds the merged write value
// WR      | one-cycle DRP write strobe
// WAIT_WR | waiting for write completion
// NEXT    | between beats of one reconfiguration; ready for the next beat
// LOCK    | mmcm_rst released; waiting for a stable lock or a timeout
module mmcm_drp_ctrl #(
  parameter int RST_HOLD     = 8,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int CORE_DELAY   = 8
) (
  input  logic            clk,
  input  logic            resetn,
  mmcm_drp_ctrl_if.slave  bus,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            mmcm_rst,
  input  logic            mmcm_locked,
  output logic            core_resetn
);

  // One down-counter is shared by the hold, DRP-wait and lock-wait phases,
  // so it is sized for the longest of them.
  localparam int TMR_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ?
                           ((LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD) :
                           ((DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int STB_W   = (CORE_DELAY > 1) ? $clog2(CORE_DELAY) : 1;

  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(RST_HOLD - 1);
  // The strobe cycle itself counts toward the DRP timeout, hence the -2.
  localparam logic [TMR_W-1:0] DRDY_LOAD = TMR_W'(DRDY_TIMEOUT - 2);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(CORE_DELAY - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    RD      = 3'd2,
    WAIT_RD = 3'd3,
    WR      = 3'd4,
    WAIT_WR = 3'd5,
    NEXT    = 3'd6,
    LOCK    = 3'd7
  } state_t;

  state_t             state, state_nx;
  logic [TMR_W-1:0]   tmr, tmr_nx;
  logic [STB_W-1:0]   stb, stb_nx;
  logic [6:0]         addr, addr_nx;
  logic [15:0]        data, data_nx;
  logic [15:0]        mask, mask_nx;
  logic               last, last_nx;
  logic [15:0]        new_val, new_nx;
  logic               ready_q, ready_nx;
  logic               busy_nx, done_nx, err_nx, rst_nx, core_nx;
  logic               lk_s1, locked_s;
  logic               accept;

  assign accept        = bus.cfg_valid & ready_q;
  assign bus.cfg_ready = ready_q;
  assign bus.drp_den   = (state == RD) || (state == WR);
  assign bus.drp_dwe   = (state == WR);
  assign bus.drp_daddr = addr;
  assign bus.drp_di    = new_val;

  // Two-flop synchroniser for the asynchronous LOCKED output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lk_s1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      lk_s1    <= mmcm_locked;
      locked_s <= lk_s1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      tmr         <= '0;
      stb         <= '0;
      addr        <= '0;
      data        <= '0;
      mask        <= '0;
      last        <= 1'b0;
      new_val     <= '0;
      ready_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      mmcm_rst    <= 1'b0;
      core_resetn <= 1'b0;
    end else begin
      state       <= state_nx;
      tmr         <= tmr_nx;
      stb         <= stb_nx;
      addr        <= addr_nx;
      data        <= data_nx;
      mask        <= mask_nx;
      last        <= last_nx;
      new_val     <= new_nx;
      ready_q     <= ready_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      err         <= err_nx;
      mmcm_rst    <= rst_nx;
      core_resetn <= core_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    stb_nx   = stb;
    addr_nx  = addr;
    data_nx  = data;
    mask_nx  = mask;
    last_nx  = last;
    new_nx   = new_val;
    busy_nx  = busy;
    done_nx  = 1'b0;
    err_nx   = err;
    rst_nx   = mmcm_rst;
    core_nx  = core_resetn;

    case (state)
      IDLE: begin
        // Lock supervision only makes sense while the MMCM is running.
        if (!mmcm_rst) begin
          if (!locked_s) begin
            core_nx = 1'b0;
            stb_nx  = '0;
          end else if (stb == STB_LAST) begin
            core_nx = 1'b1;
          end else begin
            stb_nx = stb + 1'b1;
          end
        end
        if (accept) begin
          addr_nx  = bus.cfg_addr;
          data_nx  = bus.cfg_data;
          mask_nx  = bus.cfg_mask;
          last_nx  = bus.cfg_last;
          err_nx   = 1'b0;
          busy_nx  = 1'b1;
          rst_nx   = 1'b1;
          core_nx  = 1'b0;
          stb_nx   = '0;
          tmr_nx   = HOLD_LOAD;
          state_nx = HOLD;
        end
      end

      HOLD: begin
        if (tmr == '0) state_nx = RD;
        else           tmr_nx   = tmr - 1'b1;
      end

      RD: begin
        tmr_nx   = DRDY_LOAD;
        state_nx = WAIT_RD;
      end

      WAIT_RD: begin
        if (bus.drp_drdy) begin
          new_nx   = (bus.drp_do & mask) | (data & ~mask);
          state_nx = WR;
        end else if (tmr == '0) begin
          err_nx   = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end

      WR: begin
        tmr_nx   = DRDY_LOAD;
        state_nx = WAIT_WR;
      end

      WAIT_WR: begin
        if (bus.drp_drdy) begin
          if (last) begin
            rst_nx   = 1'b0;
            tmr_nx   = LOCK_LOAD;
            stb_nx   = '0;
            state_nx = LOCK;
          end else begin
            state_nx = NEXT;
          end
        end else if (tmr == '0) begin
          err_nx   = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end

      NEXT: begin
        if (accept) begin
          addr_nx  = bus.cfg_addr;
          data_nx  = bus.cfg_data;
          mask_nx  = bus.cfg_mask;
          last_nx  = bus.cfg_last;
          state_nx = RD;
        end
      end

      LOCK: begin
        // A lock drop restarts the stability count but not the timeout.
        if (locked_s && (stb == STB_LAST)) begin
          core_nx  = 1'b1;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          if (locked_s) stb_nx = stb + 1'b1;
          else          stb_nx = '0;
          if (tmr == '0) begin
            err_nx   = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
          end else begin
            tmr_nx = tmr - 1'b1;
          end
        end
      end

      default: state_nx = IDLE;
    endcase

    ready_nx = (state_nx == IDLE) || (state_nx == NEXT);
  end

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Directed bench for mmcm_drp_ctrl: DRP register model with fixed read
// latency, MMCM lock model, and hand-computed expectations.
module tb_mmcm_drp_ctrl;
  localparam int LOCK_TO = 300;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy, done, err, mmcm_rst, core_resetn;
  logic mmcm_locked;

  mmcm_drp_ctrl_if bus ();

  mmcm_drp_ctrl #(.LOCK_TIMEOUT(LOCK_TO)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mmcm_rst    (mmcm_rst),
    .mmcm_locked (mmcm_locked),
    .core_resetn (core_resetn)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Models and monitors state
  logic [15:0] mem [128];
  logic [15:0] rdata = '0;
  int  pend = 0;
  bit  lock_mode = 1'b0;
  bit  lock_force = 1'b1;
  bit  drp_hang = 1'b0;
  int  lk_ctr = 5;
  logic [23:0] ops [$];
  int  den_cnt = 0, done_cnt = 0, rst_falls = 0, ready_viol = 0;
  bit  prev_rst = 1'b0, prev_locked = 1'b0;
  bit  hold_on = 1'b0, d2e_on = 1'b0, fall_on = 1'b0, rise_on = 1'b0;
  int  hold_n = 0, d2e_n = 0, fall_n = 0, rise_n = 0;
  int  hold_cap = -1, d2e_cap = -1, done_lat = -1, err_lat = -1, rise_lat = -1;

  function automatic logic [23:0] op_at(input int i);
    if (i < ops.size()) return ops[i];
    return 24'hFFFFFF;
  endfunction

  function automatic bit sig(input int sel);
    case (sel)
      0: return done;
      1: return err;
      2: return !mmcm_rst;
      3: return bus.drp_den && bus.drp_dwe;
      default: return 1'b0;
    endcase
  endfunction

  // DRP endpoint, MMCM lock model and event monitors, all on the falling edge
  initial begin
    bus.drp_drdy = 1'b0;
    bus.drp_do   = '0;
    mmcm_locked  = 1'b0;
    forever begin
      @(negedge clk);
      if (lock_mode) begin
        if (mmcm_rst) begin
          mmcm_locked = 1'b0;
          lk_ctr = 0;
        end else if (lk_ctr < 5) lk_ctr++;
        else mmcm_locked = 1'b1;
      end else begin
        mmcm_locked = lock_force;
      end

      bus.drp_drdy = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.drp_drdy = 1'b1;
          bus.drp_do   = rdata;
          d2e_on = 1'b0;
        end
      end
      if (bus.drp_den) begin
        den_cnt++;
        ops.push_back({bus.drp_dwe, bus.drp_daddr, bus.drp_dwe ? bus.drp_di : 16'h0});
        d2e_on = 1'b1;
        d2e_n = 0;
        if (!drp_hang) begin
          pend = 3;
          if (bus.drp_dwe) mem[bus.drp_daddr] = bus.drp_di;
          else rdata = mem[bus.drp_daddr];
        end
      end else if (d2e_on) begin
        d2e_n++;
        if (err) begin
          d2e_cap = d2e_n;
          d2e_on = 1'b0;
        end
      end

      if (bus.cfg_ready && (bus.drp_den || pend > 0)) ready_viol++;
      if (done) done_cnt++;

      if (mmcm_rst && !prev_rst) begin
        hold_on = 1'b1;
        hold_n = 0;
      end
      if (hold_on) begin
        if (bus.drp_den) begin
          hold_cap = hold_n;
          hold_on = 1'b0;
        end else hold_n++;
      end

      if (prev_rst && !mmcm_rst) begin
        fall_on = 1'b1;
        fall_n = 0;
        rst_falls++;
      end else if (fall_on) fall_n++;
      if (fall_on && done) begin
        done_lat = fall_n;
        fall_on = 1'b0;
      end
      if (fall_on && err) begin
        err_lat = fall_n;
        fall_on = 1'b0;
      end

      if (mmcm_locked && !prev_locked) begin
        rise_on = 1'b1;
        rise_n = 0;
      end else if (rise_on) rise_n++;
      if (rise_on && done) begin
        rise_lat = rise_n;
        rise_on = 1'b0;
      end

      prev_rst = mmcm_rst;
      prev_locked = mmcm_locked;
    end
  end

  // Present one beat and hold it until the controller accepts it.
  task automatic send_beat(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m,
                           input logic l);
    int n = 0;
    bus.cfg_addr  = a;
    bus.cfg_data  = d;
    bus.cfg_mask  = m;
    bus.cfg_last  = l;
    bus.cfg_valid = 1'b1;
    while (!bus.cfg_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cfg_ready) chk("cfg_ready_wait", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.cfg_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_for(input string tag, input int sel, input int max);
    int n = 0;
    while (!sig(sel) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!sig(sel)) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] exp3 [6];
    int core_at;

    bus.cfg_valid = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.cfg_mask  = '0;
    bus.cfg_last  = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    mem[8'h08] = 16'hA5A5;
    mem[8'h09] = 16'h1234;
    mem[8'h16] = 16'hFFFF;

    // 1: reset values and power-up release
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", bus.cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mmcm_rst", mmcm_rst, 0);
    chk("rst_core_resetn", core_resetn, 0);
    chk("rst_drp_den", bus.drp_den, 0);
    resetn = 1'b1;
    core_at = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (core_resetn && core_at == 0) core_at = k;
    end
    chk("pwrup_core_delay", core_at, 10);
    chk("pwrup_den_cnt", den_cnt, 0);
    chk("pwrup_done_cnt", done_cnt, 0);
    chk("pwrup_cfg_ready", bus.cfg_ready, 1);

    // 2: single masked beat
    lock_mode = 1'b1;
    ops.delete();
    done_cnt = 0;
    hold_cap = -1;
    done_lat = -1;
    send_beat(7'h08, 16'h1041, 16'hF000, 1'b1);
    wait_for("t2_done_wait", 0, 200);
    @(negedge clk);
    chk("t2_op_cnt", ops.size(), 2);
    chk("t2_rd", op_at(0), {1'b0, 7'h08, 16'h0000});
    chk("t2_wr", op_at(1), {1'b1, 7'h08, 16'hA041});
    chk("t2_hold", hold_cap, 8);
    chk("t2_done_lat", done_lat, 15);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_core", core_resetn, 1);
    chk("t2_busy", busy, 0);
    chk("t2_mmcm_rst", mmcm_rst, 0);

    // 3: three gapped beats in one reconfiguration
    ops.delete();
    rst_falls = 0;
    ready_viol = 0;
    hold_cap = -1;
    done_cnt = 0;
    send_beat(7'h08, 16'h0000, 16'hFFF0, 1'b0);
    repeat (5) @(negedge clk);
    send_beat(7'h09, 16'hABCD, 16'h0000, 1'b0);
    repeat (5) @(negedge clk);
    send_beat(7'h16, 16'h0F0F, 16'h00FF, 1'b1);
    wait_for("t3_done_wait", 0, 300);
    @(negedge clk);
    exp3[0] = {1'b0, 7'h08, 16'h0000};
    exp3[1] = {1'b1, 7'h08, 16'hA040};
    exp3[2] = {1'b0, 7'h09, 16'h0000};
    exp3[3] = {1'b1, 7'h09, 16'hABCD};
    exp3[4] = {1'b0, 7'h16, 16'h0000};
    exp3[5] = {1'b1, 7'h16, 16'h0FFF};
    chk("t3_op_cnt", ops.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_op%0d", i), op_at(i), exp3[i]);
    chk("t3_rst_falls", rst_falls, 1);
    chk("t3_ready_viol", ready_viol, 0);
    chk("t3_hold", hold_cap, 8);
    chk("t3_done_cnt", done_cnt, 1);

    // 4: DRP never answers, then a retry
    drp_hang = 1'b1;
    ops.delete();
    d2e_cap = -1;
    send_beat(7'h09, 16'h5555, 16'h00FF, 1'b1);
    wait_for("t4_err_wait", 1, 200);
    @(negedge clk);
    chk("t4_den_to_err", d2e_cap, 64);
    chk("t4_err", err, 1);
    chk("t4_mmcm_rst", mmcm_rst, 1);
    chk("t4_core", core_resetn, 0);
    chk("t4_busy", busy, 0);
    chk("t4_cfg_ready", bus.cfg_ready, 1);
    drp_hang = 1'b0;
    ops.delete();
    done_cnt = 0;
    send_beat(7'h09, 16'h5555, 16'h00FF, 1'b1);
    chk("t4_err_cleared", err, 0);
    wait_for("t4_retry_done_wait", 0, 300);
    @(negedge clk);
    chk("t4_retry_op_cnt", ops.size(), 2);
    chk("t4_retry_wr", op_at(1), {1'b1, 7'h09, 16'h55CD});
    chk("t4_retry_core", core_resetn, 1);
    chk("t4_retry_done_cnt", done_cnt, 1);

    // 5: lock glitch during the stability count, then lock timeout
    lock_mode = 1'b0;
    lock_force = 1'b1;
    done_cnt = 0;
    rise_lat = -1;
    send_beat(7'h16, 16'h0000, 16'hFFFF, 1'b1);
    lock_force = 1'b0;
    wait_for("t5_release_wait", 2, 200);
    @(posedge clk);
    #1 lock_force = 1'b1;
    repeat (3) @(posedge clk);
    #1 lock_force = 1'b0;
    @(posedge clk);
    #1 lock_force = 1'b1;
    @(negedge clk);
    wait_for("t5_done_wait", 0, 200);
    @(negedge clk);
    chk("t5_rise_to_done", rise_lat, 10);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_core", core_resetn, 1);

    err_lat = -1;
    lock_force = 1'b0;
    send_beat(7'h16, 16'h0000, 16'hFFFF, 1'b1);
    wait_for("t5_lock_to_wait", 1, LOCK_TO + 200);
    @(negedge clk);
    chk("t5_lock_timeout", err_lat, LOCK_TO);
    chk("t5_err", err, 1);
    chk("t5_to_core", core_resetn, 0);
    chk("t5_to_busy", busy, 0);
    chk("t5_to_mmcm_rst", mmcm_rst, 0);

    // 6: reset pulse while waiting for a write response
    lock_mode = 1'b1;
    send_beat(7'h08, 16'h1111, 16'h0000, 1'b1);
    wait_for("t6_wr_wait", 3, 100);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("t6_mmcm_rst", mmcm_rst, 0);
    chk("t6_den", bus.drp_den, 0);
    chk("t6_cfg_ready", bus.cfg_ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_core", core_resetn, 0);
    chk("t6_err", err, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_idle_ready", bus.cfg_ready, 1);
    ops.delete();
    done_cnt = 0;
    send_beat(7'h09, 16'h0002, 16'hFFF0, 1'b1);
    wait_for("t6_done_wait", 0, 300);
    @(negedge clk);
    chk("t6_op_cnt", ops.size(), 2);
    chk("t6_wr", op_at(1), {1'b1, 7'h09, 16'h55C2});
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_core_after", core_resetn, 1);
    chk("t6_err_after", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
